// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard metadata pipeline.
// Holds the register/Tnew widths, the RegDataSrc encodings, the per-stage
// metadata structs, the bubble constants and the saturating Tnew decrement.
package hazard_pkg;

    localparam int TNEW_W = 2;
    localparam int REG_W  = 5;
    localparam int SRC_W  = 3;

    typedef enum logic [SRC_W-1:0] {
        ALUType = 3'd0,
        MemType = 3'd1,
        PC8Type = 3'd2
    } reg_data_src_e;

    // Metadata carried by every stage from E onward.
    typedef struct packed {
        logic [TNEW_W-1:0] tnew;
        logic [REG_W-1:0]  writeReg;
        logic [SRC_W-1:0]  regDataSrc;
    } stage_info_t;

    // E additionally keeps the source operand fields for forwarding decisions.
    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        stage_info_t      info;
    } e_info_t;

    localparam stage_info_t STAGE_BUBBLE = '{tnew: '0, writeReg: '0, regDataSrc: ALUType};
    localparam e_info_t     E_BUBBLE     = '{rs: '0, rt: '0, info: STAGE_BUBBLE};

    // Tnew counts down one per stage but never wraps below zero.
    function automatic logic [TNEW_W-1:0] satDec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of hazard metadata (WriteReg, RegDataSrc, Tnew).
// Tnew is decremented with saturation as the entry is loaded; a bubble
// input replaces the whole entry with the all-zero bubble.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bubble_i,
    input  stage_info_t prev_i,
    output stage_info_t info_o
);

    stage_info_t info_d;
    stage_info_t info_q;

    // Next entry: previous stage's metadata aged by one cycle, or a bubble.
    always_comb begin
        info_d      = prev_i;
        info_d.tnew = satDec(prev_i.tnew);
        if (bubble_i) begin
            info_d = STAGE_BUBBLE;
        end
    end

    // Stage register, cleared to a bubble by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            info_q <= STAGE_BUBBLE;
        end else begin
            info_q <= info_d;
        end
    end

    assign info_o = info_q;

endmodule

// File: rtl/hazard_info_pipe.sv
// Hazard metadata pipeline: carries destination register, Tnew and result
// source from D through E, M and W alongside the datapath registers.
// Stall or FlushE inject a bubble into E; M and W always advance.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_info_pipe
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Stall,
    input  logic              FlushE,
    input  logic [TNEW_W-1:0] TnewD,
    input  logic [REG_W-1:0]  WriteRegD,
    input  logic [SRC_W-1:0]  RegDataSrcD,
    input  logic [REG_W-1:0]  Instr25_21D,
    input  logic [REG_W-1:0]  Instr20_16D,
    output logic [TNEW_W-1:0] TnewE,
    output logic [REG_W-1:0]  Instr25_21E,
    output logic [REG_W-1:0]  Instr20_16E,
    output logic [REG_W-1:0]  WriteRegE,
    output logic [SRC_W-1:0]  RegDataSrcE,
    output logic [TNEW_W-1:0] TnewM,
    output logic [REG_W-1:0]  WriteRegM,
    output logic [SRC_W-1:0]  RegDataSrcM,
    output logic [TNEW_W-1:0] TnewW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic [31:0]       StallCount
);

    e_info_t     eInfo_d;
    e_info_t     eInfo_q;
    stage_info_t mInfo;
    stage_info_t wInfo;

    // E loader: bubble on stall/flush; an instruction with no destination
    // never produces a result, so its Tnew is forced to zero.
    always_comb begin
        eInfo_d = E_BUBBLE;
        if (!(Stall || FlushE)) begin
            eInfo_d.rs              = Instr25_21D;
            eInfo_d.rt              = Instr20_16D;
            eInfo_d.info.writeReg   = WriteRegD;
            eInfo_d.info.regDataSrc = RegDataSrcD;
            eInfo_d.info.tnew       = (WriteRegD == '0) ? '0 : TnewD;
        end
    end

    // E stage register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eInfo_q <= E_BUBBLE;
        end else begin
            eInfo_q <= eInfo_d;
        end
    end

    hazard_stage_reg u_stageM (
        .clk      (clk),
        .reset_n  (reset_n),
        .bubble_i (1'b0),
        .prev_i   (eInfo_q.info),
        .info_o   (mInfo)
    );

    hazard_stage_reg u_stageW (
        .clk      (clk),
        .reset_n  (reset_n),
        .bubble_i (1'b0),
        .prev_i   (mInfo),
        .info_o   (wInfo)
    );

    assign TnewE       = eInfo_q.info.tnew;
    assign Instr25_21E = eInfo_q.rs;
    assign Instr20_16E = eInfo_q.rt;
    assign WriteRegE   = eInfo_q.info.writeReg;
    assign RegDataSrcE = eInfo_q.info.regDataSrc;
    assign TnewM       = mInfo.tnew;
    assign WriteRegM   = mInfo.writeReg;
    assign RegDataSrcM = mInfo.regDataSrc;
    assign TnewW       = wInfo.tnew;
    assign WriteRegW   = wInfo.writeReg;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stallCount_q;

    // Count cycles sampled with Stall high, holding at the maximum value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCount_q <= '0;
        end else if (Stall && (stallCount_q != '1)) begin
            stallCount_q <= stallCount_q + 32'd1;
        end
    end

    assign StallCount = stallCount_q;
`else
    assign StallCount = '0;
`endif

endmodule
